rgb_stream_packer: RTL and testbench

//  Packs 24-bit RGB pixels from the pixel generator into a 32-bit AXI4-Stream video bus (4 pixels -> 3 words).

---
 rtl/rgb_stream_packer_if.sv | 27 ++
 rtl/rgb_stream_packer.sv | 191 +++++++++++++++++++
 tb/tb_rgb_stream_packer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_stream_packer_if.sv
// Pixel-side and AXI4-Stream-side bundles for rgb_stream_packer.
// master drives the payload, slave drives the ready.

interface rgb_pixel_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       valid;
    logic       sof;
    logic       eol;
    logic       ready;

    modport master (output r, g, b, valid, sof, eol, input ready);
    modport slave  (input r, g, b, valid, sof, eol, output ready);
endinterface

interface rgb_axis_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels 4:3 into 32-bit AXI4-Stream words, zero-padding line ends.
// Define PACKER_XRGB_EN to emit one pixel per word ({8'h00,b,g,r}) instead.

module rgb_stream_packer (
    input  logic       aclk,
    input  logic       areset,
    rgb_pixel_if.slave pix,
    rgb_axis_if.master axis,
    output logic       sync_err
);

    typedef enum logic {PACK, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [23:0] left_q, left_d;
    logic [3:0]  fkeep_q, fkeep_d;
    logic        sof_pend_q, sof_pend_d;

    logic [31:0] tdata_p0;
    logic [3:0]  tkeep_p0;
    logic        tlast_p0;
    logic        tuser_p0;
    logic        vld_p0;

    logic        push;
    logic [31:0] push_data;
    logic [3:0]  push_keep;
    logic        push_last;
    logic        push_user;
    logic        serr_d;

    logic        slot_free;
    logic        acc;
    logic [1:0]  eff_phase;
    logic        pend_sof;

    assign slot_free = !vld_p0 || axis.tready;
    assign pix.ready = (state_q == PACK) && slot_free;
    assign acc       = pix.valid && pix.ready;
    // A sof pixel always restarts the group, whatever phase we were in.
    assign eff_phase = pix.sof ? 2'd0 : phase_q;
    assign pend_sof  = sof_pend_q || pix.sof;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        left_d     = left_q;
        fkeep_d    = fkeep_q;
        sof_pend_d = sof_pend_q;
        push       = 1'b0;
        push_data  = 32'h0;
        push_keep  = 4'h0;
        push_last  = 1'b0;
        push_user  = 1'b0;
        serr_d     = 1'b0;
`ifdef PACKER_XRGB_EN
        if (acc) begin
            push      = 1'b1;
            push_data = {8'h00, pix.b, pix.g, pix.r};
            push_keep = 4'hF;
            push_last = pix.eol;
            push_user = pix.sof;
        end
`else
        case (state_q)
            PACK: begin
                if (acc) begin
                    serr_d = pix.sof && (phase_q != 2'd0);
                    case (eff_phase)
                        2'd0: begin
                            if (pix.eol) begin
                                push       = 1'b1;
                                push_data  = {8'h00, pix.b, pix.g, pix.r};
                                push_keep  = 4'h7;
                                push_last  = 1'b1;
                                push_user  = pend_sof;
                                sof_pend_d = 1'b0;
                                left_d     = 24'h0;
                                phase_d    = 2'd0;
                            end else begin
                                left_d     = {pix.b, pix.g, pix.r};
                                sof_pend_d = pend_sof;
                                phase_d    = 2'd1;
                            end
                        end
                        2'd1: begin
                            push       = 1'b1;
                            push_data  = {pix.r, left_q};
                            push_keep  = 4'hF;
                            push_user  = pend_sof;
                            sof_pend_d = 1'b0;
                            left_d     = {8'h00, pix.b, pix.g};
                            if (pix.eol) begin
                                fkeep_d = 4'h3;
                                state_d = FLUSH;
                                phase_d = 2'd0;
                            end else begin
                                phase_d = 2'd2;
                            end
                        end
                        2'd2: begin
                            push       = 1'b1;
                            push_data  = {pix.g, pix.r, left_q[15:0]};
                            push_keep  = 4'hF;
                            push_user  = pend_sof;
                            sof_pend_d = 1'b0;
                            left_d     = {16'h0000, pix.b};
                            if (pix.eol) begin
                                fkeep_d = 4'h1;
                                state_d = FLUSH;
                                phase_d = 2'd0;
                            end else begin
                                phase_d = 2'd3;
                            end
                        end
                        default: begin
                            push       = 1'b1;
                            push_data  = {pix.b, pix.g, pix.r, left_q[7:0]};
                            push_keep  = 4'hF;
                            push_last  = pix.eol;
                            push_user  = pend_sof;
                            sof_pend_d = 1'b0;
                            left_d     = 24'h0;
                            phase_d    = 2'd0;
                        end
                    endcase
                end
            end
            FLUSH: begin
                // Leftover bytes above the kept count are already zero.
                if (slot_free) begin
                    push       = 1'b1;
                    push_data  = {8'h00, left_q};
                    push_keep  = fkeep_q;
                    push_last  = 1'b1;
                    push_user  = sof_pend_q;
                    sof_pend_d = 1'b0;
                    left_d     = 24'h0;
                    state_d    = PACK;
                end
            end
            default: state_d = PACK;
        endcase
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= PACK;
            phase_q    <= 2'd0;
            left_q     <= 24'h0;
            fkeep_q    <= 4'h0;
            sof_pend_q <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            left_q     <= left_d;
            fkeep_q    <= fkeep_d;
            sof_pend_q <= sof_pend_d;
            sync_err   <= serr_d;
        end
    end

    // Stage p0: single-entry output register, held while stalled by tready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_p0   <= 1'b0;
            tdata_p0 <= 32'h0;
            tkeep_p0 <= 4'h0;
            tlast_p0 <= 1'b0;
            tuser_p0 <= 1'b0;
        end else if (push) begin
            vld_p0   <= 1'b1;
            tdata_p0 <= push_data;
            tkeep_p0 <= push_keep;
            tlast_p0 <= push_last;
            tuser_p0 <= push_user;
        end else if (axis.tready) begin
            vld_p0   <= 1'b0;
        end
    end

    assign axis.tvalid = vld_p0;
    assign axis.tdata  = tdata_p0;
    assign axis.tkeep  = tkeep_p0;
    assign axis.tlast  = tlast_p0;
    assign axis.tuser  = tuser_p0;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed bench for rgb_stream_packer: byte-queue scoreboard checks every output word.

module tb_rgb_stream_packer;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic sync_err;

    rgb_pixel_if pix_if ();
    rgb_axis_if  axis_if ();

    rgb_stream_packer dut (
        .aclk     (aclk),
        .areset   (areset),
        .pix      (pix_if),
        .axis     (axis_if),
        .sync_err (sync_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } word_t;

`ifdef PACKER_XRGB_EN
    localparam int WORDS_PER_640 = 640;
    localparam int SERR_AT_PH2   = 0;
`else
    localparam int WORDS_PER_640 = 480;
    localparam int SERR_AT_PH2   = 1;
`endif

    word_t       exp_q[$];
    logic [8:0]  bq[$];
    int          checks = 0;
    int          errors = 0;
    int          serr_exp = 0;
    int          serr_seen = 0;
    int          words_seen = 0;
    int          lasts_seen = 0;
    logic [31:0] last_user_data = 32'h0;

    // Pops n stream bytes from the model queue into one expected word.
    function automatic void emit(int n, bit last);
        word_t      w;
        logic [8:0] e;
        w = '0;
        for (int i = 0; i < n; i++) begin
            e = bq.pop_front();
            w.data[8*i +: 8] = e[7:0];
            w.keep[i] = 1'b1;
            w.user = w.user | e[8];
        end
        w.last = last;
        exp_q.push_back(w);
    endfunction

    function automatic void model_accept(logic [7:0] r, logic [7:0] g, logic [7:0] b, bit sof, bit eol);
`ifdef PACKER_XRGB_EN
        word_t w;
        w.data = {8'h00, b, g, r};
        w.keep = 4'hF;
        w.last = eol;
        w.user = sof;
        exp_q.push_back(w);
`else
        if (sof && bq.size() != 0) begin
            serr_exp++;
            bq.delete();
        end
        bq.push_back({sof, r});
        bq.push_back({1'b0, g});
        bq.push_back({1'b0, b});
        while (bq.size() >= 4) emit(4, eol && (bq.size() == 4));
        if (eol && bq.size() != 0) emit(bq.size(), 1'b1);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        word_t e;
        word_t got;
        if (sync_err) serr_seen++;
        if (!areset && axis_if.tvalid && axis_if.tready) begin
            words_seen++;
            if (axis_if.tlast) lasts_seen++;
            got = {axis_if.tdata, axis_if.tkeep, axis_if.tlast, axis_if.tuser};
            if (got.user) last_user_data = got.data;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_word got data=%h keep=%h", got.data, got.keep);
            end else begin
                e = exp_q.pop_front();
                assert (got === e) else begin
                    errors++;
                    $error("FAIL word got data=%h keep=%h last=%b user=%b exp data=%h keep=%h last=%b user=%b",
                           got.data, got.keep, got.last, got.user, e.data, e.keep, e.last, e.user);
                end
            end
        end
    end

    task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input bit sof, input bit eol);
        int n;
        n = 0;
        pix_if.r = r;
        pix_if.g = g;
        pix_if.b = b;
        pix_if.sof = sof;
        pix_if.eol = eol;
        pix_if.valid = 1'b1;
        @(negedge aclk);
        while (!pix_if.ready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        if (!pix_if.ready) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout got ready=0 exp ready=1");
        end else begin
            model_accept(r, g, b, sof, eol);
        end
        @(posedge aclk);
        #1;
        pix_if.valid = 1'b0;
        pix_if.sof = 1'b0;
        pix_if.eol = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(posedge aclk);
        end
        @(posedge aclk);
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int l0;
        int s0;
        logic [31:0] hd;
        logic [3:0]  hk;
        logic        hl;

        pix_if.r = 8'h0;
        pix_if.g = 8'h0;
        pix_if.b = 8'h0;
        pix_if.valid = 1'b0;
        pix_if.sof = 1'b0;
        pix_if.eol = 1'b0;
        axis_if.tready = 1'b1;

        // Reset state
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        chk("rst_tvalid", axis_if.tvalid, 0);
        chk("rst_tdata", axis_if.tdata, 0);
        chk("rst_tkeep", axis_if.tkeep, 0);
        chk("rst_tlast", axis_if.tlast, 0);
        chk("rst_tuser", axis_if.tuser, 0);
        chk("rst_sync_err", sync_err, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Two 640-pixel lines at full rate, r=x g=y b=x+y
        w0 = words_seen;
        l0 = lasts_seen;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 640; x++)
                send_pix(8'(x), 8'(y), 8'(x + y), (x == 0) && (y == 0), x == 639);
        drain();
        chk("w640_words", words_seen - w0, 2 * WORDS_PER_640);
        chk("w640_lasts", lasts_seen - l0, 2);

        // Width 5: three full words then a 3-byte tail
        w0 = words_seen;
        for (int i = 0; i < 5; i++)
            send_pix(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 1'b0, i == 4);
        drain();
        chk("w5_words", words_seen - w0, (WORDS_PER_640 == 480) ? 4 : 5);

        // Width 6: eol at phase 1 stalls input for the flush word
        for (int i = 0; i < 6; i++)
            send_pix(8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i), 1'b0, i == 5);
`ifndef PACKER_XRGB_EN
        @(negedge aclk);
        chk("w6_ready_flush", pix_if.ready, 0);
        @(negedge aclk);
        chk("w6_ready_after", pix_if.ready, 1);
        @(posedge aclk);
        #1;
`endif
        for (int i = 0; i < 3; i++)
            send_pix(8'(8'h70 + i), 8'(8'h71 + i), 8'(8'h72 + i), 1'b0, i == 2);
        drain();

        // tready low mid-line: output held, input stalled, nothing lost
        for (int i = 0; i < 5; i++)
            send_pix(8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i), 1'b0, 1'b0);
        axis_if.tready = 1'b0;
        send_pix(8'h85, 8'h95, 8'hA5, 1'b0, 1'b0);
        pix_if.r = 8'h86;
        pix_if.g = 8'h96;
        pix_if.b = 8'hA6;
        pix_if.valid = 1'b1;
        @(negedge aclk);
        chk("stall_tvalid", axis_if.tvalid, 1);
        hd = axis_if.tdata;
        hk = axis_if.tkeep;
        hl = axis_if.tlast;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("stall_tdata", axis_if.tdata, hd);
            chk("stall_tkeep", 32'(axis_if.tkeep), 32'(hk));
            chk("stall_tlast", axis_if.tlast, hl);
            chk("stall_ready", pix_if.ready, 0);
        end
        @(posedge aclk);
        #1;
        axis_if.tready = 1'b1;
        for (int i = 6; i < 12; i++)
            send_pix(8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i), 1'b0, i == 11);
        drain();

        // sof arriving at phase 2
        s0 = serr_seen;
        send_pix(8'hB0, 8'hC0, 8'hD0, 1'b0, 1'b0);
        send_pix(8'hB1, 8'hC1, 8'hD1, 1'b0, 1'b0);
        send_pix(8'hB2, 8'hC2, 8'hD2, 1'b1, 1'b0);
        send_pix(8'hB3, 8'hC3, 8'hD3, 1'b0, 1'b0);
        send_pix(8'hB4, 8'hC4, 8'hD4, 1'b0, 1'b1);
        drain();
        chk("sof_sync_err", serr_seen - s0, SERR_AT_PH2);
        chk("sof_word_r", last_user_data[7:0], 8'hB2);

        // Asynchronous reset during FLUSH with a stalled output word
        axis_if.tready = 1'b0;
        send_pix(8'hE0, 8'hE1, 8'hE2, 1'b0, 1'b0);
        send_pix(8'hE3, 8'hE4, 8'hE5, 1'b0, 1'b1);
        @(negedge aclk);
        chk("flush_tvalid", axis_if.tvalid, 1);
        #2;
        areset = 1'b1;
        #1;
        chk("arst_tvalid", axis_if.tvalid, 0);
        chk("arst_tdata", axis_if.tdata, 0);
        chk("arst_tkeep", axis_if.tkeep, 0);
        chk("arst_tlast", axis_if.tlast, 0);
        exp_q.delete();
        bq.delete();
        @(posedge aclk);
        #1;
        areset = 1'b0;
        axis_if.tready = 1'b1;
        w0 = words_seen;
        for (int i = 0; i < 4; i++)
            send_pix(8'(8'hF0 + i), 8'(8'hF4 + i), 8'(8'hF8 + i), 1'b0, i == 3);
        drain();
        chk("post_rst_words", words_seen - w0, (WORDS_PER_640 == 480) ? 3 : 4);

        chk("sync_err_total", serr_seen, serr_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
